// File: rtl/if_fetch_stage_pkg.sv
// rtl/if_fetch_stage_pkg.sv - shared constants, state encoding and helpers for the fetch stage
package if_fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_REQ  = 2'd1,
        IF_DROP = 2'd2,
        IF_HOLD = 2'd3
    } if_state_e;

    // Branch targets are word addresses; the low two bits are forced to zero.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_stage_pc_register.sv
// rtl/if_fetch_stage_pc_register.sv - program counter register with load enable
module pc_register #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_en,
    input  logic [31:0] pc_in,
    output logic [31:0] pc_out
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    // Take the new value only when the fetch logic asks for it.
    always_comb begin
        pc_d = pc_q;
        if (load_en) begin
            pc_d = pc_in;
        end
    end

    // PC storage; reset returns to the boot address.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_out = pc_q;

endmodule

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - MIPS instruction fetch stage with req/ack memory port
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_plus4,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        ifid_flush
);

    if_state_e   state_q;
    if_state_e   state_d;
    logic [31:0] drop_addr_q;
    logic [31:0] drop_addr_d;
    logic [31:0] hold_instr_q;
    logic [31:0] hold_instr_d;

    logic [31:0] pc;
    logic [31:0] pc_d;
    logic        pc_load;
    logic [31:0] pc_inc;
    logic [31:0] target;

    assign pc_inc = pc + 32'd4;
    assign target = word_align(br_target);

    pc_register #(
        .RESET_PC (RESET_PC)
    ) u_pc_register (
        .clk     (clk),
        .rst     (rst),
        .load_en (pc_load),
        .pc_in   (pc_d),
        .pc_out  (pc)
    );

    // Next state: a redirect always wins over freeze; a fetch abandoned by a
    // redirect keeps its address in DROP until memory answers it.
    always_comb begin
        state_d      = state_q;
        drop_addr_d  = drop_addr_q;
        hold_instr_d = hold_instr_q;
        pc_d         = pc;
        pc_load      = 1'b0;
        case (state_q)
            IF_IDLE: begin
                state_d = IF_REQ;
                if (br_taken) begin
                    pc_d    = target;
                    pc_load = 1'b1;
                end
            end
            IF_REQ: begin
                if (br_taken) begin
                    pc_d    = target;
                    pc_load = 1'b1;
                    if (!imem_ack) begin
                        drop_addr_d = pc;
                        state_d     = IF_DROP;
                    end
                end else if (imem_ack) begin
                    if (freeze) begin
                        hold_instr_d = imem_rdata;
                        state_d      = IF_HOLD;
                    end else begin
                        pc_d    = pc_inc;
                        pc_load = 1'b1;
                    end
                end
            end
            IF_DROP: begin
                if (br_taken) begin
                    pc_d    = target;
                    pc_load = 1'b1;
                end
                if (imem_ack) begin
                    state_d = IF_REQ;
                end
            end
            IF_HOLD: begin
                if (br_taken) begin
                    pc_d    = target;
                    pc_load = 1'b1;
                    state_d = IF_REQ;
                end else if (!freeze) begin
                    pc_d    = pc_inc;
                    pc_load = 1'b1;
                    state_d = IF_REQ;
                end
            end
            default: begin
                state_d = IF_IDLE;
            end
        endcase
    end

    // State, abandoned-request address and frozen instruction registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IF_IDLE;
            drop_addr_q  <= 32'h0;
            hold_instr_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            drop_addr_q  <= drop_addr_d;
            hold_instr_q <= hold_instr_d;
        end
    end

    // Outputs are combinational from state and the memory response.
    always_comb begin
        imem_req    = 1'b0;
        imem_addr   = pc;
        instr       = NOP_INSTR;
        pc_plus4    = pc_inc;
        instr_valid = 1'b0;
        case (state_q)
            IF_REQ: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    instr       = imem_rdata;
                    instr_valid = 1'b1;
                end
            end
            IF_DROP: begin
                imem_req  = 1'b1;
                imem_addr = drop_addr_q;
            end
            IF_HOLD: begin
                instr       = hold_instr_q;
                instr_valid = 1'b1;
            end
            default: begin
                imem_req = 1'b0;
            end
        endcase
    end

    assign ifid_flush = br_taken | ~instr_valid;

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - self-checking bench for if_fetch_stage
module tb_if_fetch_stage;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        br_taken;
    logic [31:0] br_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic        instr_valid;
    logic        ifid_flush;

    int errors;
    int checks;

    // memory responder
    int mem_lat;
    int mem_cnt;

    // reference model: transaction-level view of the fetch unit
    bit          m_known;
    bit          m_fresh;
    logic [31:0] m_pc;
    bit          m_stale;
    logic [31:0] m_stale_addr;
    bit          m_hold;
    logic [31:0] m_hold_word;

    // last sampled outputs, for literal checks
    logic        s_req;
    logic [31:0] s_addr;
    logic [31:0] s_instr;
    logic [31:0] s_pp4;
    logic        s_valid;
    logic        s_flush;

    if_fetch_stage #(
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .freeze      (freeze),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .pc_plus4    (pc_plus4),
        .instr       (instr),
        .instr_valid (instr_valid),
        .ifid_flush  (ifid_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[31:16] ^ 16'h5A3C} + 32'h1357_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, answer memory, compare against the model,
    // advance the model, then move to just after the next rising edge.
    task automatic step(input logic r, input logic f, input logic b, input logic [31:0] t);
        logic        e_req;
        logic        e_valid;
        logic [31:0] tgt;
        logic        ack;
        rst       = r;
        freeze    = f;
        br_taken  = b;
        br_target = t;
        ack        = imem_req && (mem_cnt >= mem_lat - 1);
        imem_ack   = ack;
        imem_rdata = ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;
        tgt        = {t[31:2], 2'b00};
        #3;
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_instr = instr;
        s_pp4   = pc_plus4;
        s_valid = instr_valid;
        s_flush = ifid_flush;

        if (m_known) begin
            if (m_fresh) begin
                e_req   = 1'b0;
                e_valid = 1'b0;
                chk("idle_addr", imem_addr, m_pc);
                chk("idle_instr", instr, 32'h0);
                chk("idle_pc_plus4", pc_plus4, m_pc + 32'd4);
            end else if (m_hold) begin
                e_req   = 1'b0;
                e_valid = 1'b1;
                chk("hold_instr", instr, m_hold_word);
                chk("hold_pc_plus4", pc_plus4, m_pc + 32'd4);
            end else if (m_stale) begin
                e_req   = 1'b1;
                e_valid = 1'b0;
                chk("drop_addr", imem_addr, m_stale_addr);
            end else begin
                e_req   = 1'b1;
                e_valid = ack;
                chk("req_addr", imem_addr, m_pc);
                if (ack) begin
                    chk("req_instr", instr, mem_word(m_pc));
                    chk("req_pc_plus4", pc_plus4, m_pc + 32'd4);
                end
            end
            chk("imem_req", {31'h0, imem_req}, {31'h0, e_req});
            chk("instr_valid", {31'h0, instr_valid}, {31'h0, e_valid});
            chk("ifid_flush", {31'h0, ifid_flush}, {31'h0, b | ~e_valid});
            if (instr_valid && !ifid_flush) begin
                chk("presented_word", instr, mem_word(pc_plus4 - 32'd4));
            end
        end

        if (r) begin
            m_known = 1'b1;
            m_fresh = 1'b1;
            m_pc    = 32'h0;
            m_stale = 1'b0;
            m_hold  = 1'b0;
        end else if (m_fresh) begin
            m_fresh = 1'b0;
            if (b) m_pc = tgt;
        end else if (m_hold) begin
            if (b) begin
                m_pc   = tgt;
                m_hold = 1'b0;
            end else if (!f) begin
                m_pc   = m_pc + 32'd4;
                m_hold = 1'b0;
            end
        end else if (m_stale) begin
            if (b) m_pc = tgt;
            if (ack) m_stale = 1'b0;
        end else begin
            if (b) begin
                if (!ack) begin
                    m_stale      = 1'b1;
                    m_stale_addr = m_pc;
                end
                m_pc = tgt;
            end else if (ack) begin
                if (f) begin
                    m_hold      = 1'b1;
                    m_hold_word = mem_word(m_pc);
                end else begin
                    m_pc = m_pc + 32'd4;
                end
            end
        end

        if (!imem_req || ack) mem_cnt = 0;
        else mem_cnt++;

        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        r;
        logic        f;
        logic        b;
        logic [31:0] t;
        errors     = 0;
        checks     = 0;
        mem_lat    = 1;
        mem_cnt    = 0;
        m_known    = 1'b0;
        m_fresh    = 1'b1;
        m_pc       = 32'h0;
        m_stale    = 1'b0;
        m_hold     = 1'b0;
        m_stale_addr = 32'h0;
        m_hold_word  = 32'h0;
        rst        = 1'b1;
        freeze     = 1'b0;
        br_taken   = 1'b0;
        br_target  = 32'h0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        @(posedge clk);
        #1;

        // reset state
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("rst_req", {31'h0, s_req}, 32'h0);
        chk("rst_addr", s_addr, 32'h0);
        chk("rst_instr", s_instr, 32'h0);
        chk("rst_pc_plus4", s_pp4, 32'h4);
        chk("rst_valid", {31'h0, s_valid}, 32'h0);
        chk("rst_flush", {31'h0, s_flush}, 32'h1);

        // ack tied high: back-to-back fetches
        step(0, 0, 0, 0);
        chk("idle_after_rst_req", {31'h0, s_req}, 32'h0);
        step(0, 0, 0, 0);
        chk("seq0_addr", s_addr, 32'h0);
        chk("seq0_pp4", s_pp4, 32'h4);
        chk("seq0_valid", {31'h0, s_valid}, 32'h1);
        step(0, 0, 0, 0);
        chk("seq1_addr", s_addr, 32'h4);
        chk("seq1_pp4", s_pp4, 32'h8);

        // freeze on the word at 8 for three cycles
        step(0, 1, 0, 0);
        chk("frz_addr", s_addr, 32'h8);
        chk("frz_pp4", s_pp4, 32'hC);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("frz_req", {31'h0, s_req}, 32'h0);
        chk("frz_instr", s_instr, mem_word(32'h8));
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("frz_next_addr", s_addr, 32'hC);

        // redirect with single-cycle memory
        step(0, 0, 1, 32'h40);
        chk("br_addr", s_addr, 32'h10);
        chk("br_flush", {31'h0, s_flush}, 32'h1);
        step(0, 0, 1, 32'h14);
        chk("br_target_addr", s_addr, 32'h40);

        // redirect while a slow fetch is outstanding
        mem_lat = 3;
        step(0, 0, 1, 32'h80);
        chk("slow_addr0", s_addr, 32'h14);
        step(0, 0, 0, 0);
        chk("slow_addr1", s_addr, 32'h14);
        step(0, 0, 0, 0);
        chk("slow_addr2", s_addr, 32'h14);
        chk("slow_drop_valid", {31'h0, s_valid}, 32'h0);
        mem_lat = 1;
        step(0, 0, 1, 32'h103);
        chk("slow_next_addr", s_addr, 32'h80);

        // misaligned target and address wrap
        step(0, 0, 1, 32'hFFFF_FFFC);
        chk("misalign_addr", s_addr, 32'h100);
        step(0, 0, 0, 0);
        chk("wrap_addr", s_addr, 32'hFFFF_FFFC);
        chk("wrap_pp4", s_pp4, 32'h0);
        step(0, 0, 0, 0);
        chk("wrap_next_addr", s_addr, 32'h0);

        // reset while a dropped fetch is outstanding
        mem_lat = 3;
        step(0, 0, 1, 32'h200);
        step(1, 0, 0, 0);
        chk("rst_drop_req_before", {31'h0, s_req}, 32'h1);
        step(0, 0, 0, 0);
        chk("rst_drop_req", {31'h0, s_req}, 32'h0);
        chk("rst_drop_addr", s_addr, 32'h0);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ((i % 64) == 0) mem_lat = $urandom_range(1, 4);
            r = ($urandom_range(0, 199) == 0);
            f = ($urandom_range(0, 99) < 30);
            b = ($urandom_range(0, 99) < 12);
            case ($urandom_range(0, 2))
                0:       t = $urandom;
                1:       t = 32'($urandom_range(0, 255));
                default: t = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            endcase
            step(r, f, b, t);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
